// File: rtl/fetch_queue.sv
// fetch_queue: sequential instruction fetch with a DEPTH-entry PC-tagged queue.
// It issues one request per cycle to a 1-cycle-latency memory, and a credit
// check on (occupancy + in-flight) keeps the queue from overflowing. The queue
// head is offered to decode through a valid/ready handshake. A redirect flushes
// the queue, kills the in-flight response and restarts fetch at the target.
module fetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter int                PC_STEP  = 1,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_i,
  input  logic [ADDR_W-1:0]        redirect_pc_i,
  output logic                     imem_req_o,
  output logic [ADDR_W-1:0]        imem_addr_o,
  input  logic [INSTR_W-1:0]       imem_rdata_i,
  output logic                     instr_valid_o,
  output logic [INSTR_W-1:0]       instr_o,
  output logic [ADDR_W-1:0]        instr_pc_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Compare limit is one bit wider than the count so count+inflight cannot wrap.
  localparam logic [CNT_W:0] DEPTH_LIM = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0]  pc_reg;
  logic [ADDR_W-1:0]  tag_reg;
  logic               inflight_reg;
  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   count_next;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];

  logic [CNT_W:0]     credit_used;
  logic               req;
  logic               push;
  logic               pop;

  // Slots already committed are the stored entries plus the response in flight.
  assign credit_used = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};

  // A request only issues when its response is guaranteed a slot.
  assign req  = !rst && !redirect_i && (credit_used < DEPTH_LIM);
  // A redirect kills the response arriving this cycle.
  assign push = inflight_reg && !redirect_i;
  assign pop  = instr_valid_o && instr_ready_i;

  assign imem_req_o    = req;
  assign imem_addr_o   = pc_reg;
  assign instr_valid_o = (count_reg != '0) && !redirect_i;
  assign instr_o       = instr_mem[rd_ptr_reg];
  assign instr_pc_o    = pc_mem[rd_ptr_reg];
  assign count_o       = count_reg;

  // Occupancy: a simultaneous push and pop leave it unchanged.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Fetch PC, in-flight tracking, pointers and count; a redirect overrides everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      tag_reg      <= RESET_PC;
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else if (redirect_i) begin
      pc_reg       <= redirect_pc_i;
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      inflight_reg <= req;
      if (req) begin
        pc_reg  <= pc_reg + ADDR_W'(PC_STEP);
        tag_reg <= pc_reg;
      end
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_next;
    end
  end

  // Queue storage: each entry captures the returned word and its tag PC on push.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gen_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PTR_W'(gi))) begin
        instr_mem[gi] <= imem_rdata_i;
        pc_mem[gi]    <= tag_reg;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard of expected pops.
// The stimulus pushes hand-computed {pc, instr} pairs; a monitor pops and
// compares on every accepted handshake. Memory returns addr + 0x100.
module tb_fetch_queue;

  localparam int ADDR_W = 8;
  localparam int INSTR_W = 32;
  localparam int DEPTH = 4;

  logic               clk;
  logic               rst;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_ready;
  logic [2:0]         count;

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [ADDR_W-1:0] wrap_addr [4];

  fetch_queue #(
    .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .PC_STEP(1), .RESET_PC(8'h00)
  ) dut (
    .clk(clk), .rst(rst),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_rdata_i(imem_rdata),
    .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(instr_ready), .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory, 1-cycle latency: word at addr is 0x100 + addr.
  always @(posedge clk) imem_rdata <= 32'h100 + {24'h0, imem_addr};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req_v);
    n_cmp++;
    if (got !== req_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req_v);
    end
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] pc, input logic [INSTR_W-1:0] ins);
    exp_t e;
    e.pc = pc;
    e.instr = ins;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset for one cycle and checks the reset state; returns at the start of cycle 0.
  task automatic do_reset(input logic rdy);
    tick();
    rst = 1'b1;
    redirect = 1'b0;
    instr_ready = rdy;
    @(negedge clk);
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_req", 32'(imem_req), 0);
    tick();
    rst = 1'b0;
  endtask

  // Monitor: every accepted handshake is checked against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pop: got pc 0x%0h instr 0x%0h, required no pop", instr_pc, instr);
      end else begin
        mon_e = exp_q.pop_front();
        $display("pop pc=0x%02h instr=0x%08h", instr_pc, instr);
        if (instr_pc !== mon_e.pc || instr !== mon_e.instr) begin
          n_bad++;
          $display("FAIL pop_data: got pc 0x%0h instr 0x%0h, required pc 0x%0h instr 0x%0h",
                   instr_pc, instr, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    instr_ready = 1'b0;
    wrap_addr[0] = 8'hFE;
    wrap_addr[1] = 8'hFF;
    wrap_addr[2] = 8'h00;
    wrap_addr[3] = 8'h01;

    // Stream: ready=1, sequential requests, first valid two cycles after the first request.
    do_reset(1'b1);
    push_exp(8'h00, 32'h100); push_exp(8'h01, 32'h101);
    push_exp(8'h02, 32'h102); push_exp(8'h03, 32'h103);
    push_exp(8'h04, 32'h104); push_exp(8'h05, 32'h105);
    push_exp(8'h06, 32'h106); push_exp(8'h07, 32'h107);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      chk("stream_req", 32'(imem_req), 1);
      chk("stream_addr", 32'(imem_addr), 32'(k));
      if (k < 2) chk("stream_valid_latency", 32'(instr_valid), 0);
      if (k == 2) chk("stream_valid_rise", 32'(instr_valid), 1);
    end

    // Back-pressure: four requests, then stall with PC held at 4, then drain and resume.
    do_reset(1'b0);
    push_exp(8'h00, 32'h100); push_exp(8'h01, 32'h101);
    push_exp(8'h02, 32'h102); push_exp(8'h03, 32'h103);
    push_exp(8'h04, 32'h104); push_exp(8'h05, 32'h105);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) tick();
      if (k == 7) instr_ready = 1'b1;
      @(negedge clk);
      if (k < 4) begin
        chk("bp_req", 32'(imem_req), 1);
        chk("bp_addr", 32'(imem_addr), 32'(k));
      end
      if (k >= 4 && k <= 7) chk("bp_req_stall", 32'(imem_req), 0);
      if (k == 4) chk("bp_count3", 32'(count), 3);
      if (k == 5 || k == 6) begin
        chk("bp_count_full", 32'(count), 4);
        chk("bp_pc_hold", 32'(imem_addr), 4);
      end
      if (k == 8) begin
        chk("bp_resume_req", 32'(imem_req), 1);
        chk("bp_resume_addr", 32'(imem_addr), 4);
        chk("bp_resume_count", 32'(count), 3);
      end
    end

    // Redirect with count=2 and a response in flight, then a redirect that wraps the PC.
    do_reset(1'b0);
    push_exp(8'h40, 32'h140); push_exp(8'h41, 32'h141); push_exp(8'h42, 32'h142);
    push_exp(8'hFE, 32'h1FE); push_exp(8'hFF, 32'h1FF);
    push_exp(8'h00, 32'h100); push_exp(8'h01, 32'h101);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      redirect = (k == 3) || (k == 9);
      redirect_pc = (k == 9) ? 8'hFE : 8'h40;
      if (k == 3) instr_ready = 1'b1;
      @(negedge clk);
      if (k == 3) begin
        chk("redir_pre_count", 32'(count), 2);
        chk("redir_no_req", 32'(imem_req), 0);
        chk("redir_no_valid", 32'(instr_valid), 0);
      end
      if (k == 4) begin
        chk("redir_flush_count", 32'(count), 0);
        chk("redir_req", 32'(imem_req), 1);
        chk("redir_addr", 32'(imem_addr), 32'h40);
      end
      if (k == 5) begin
        chk("redir_stale_dropped", 32'(count), 0);
        chk("redir_valid_low", 32'(instr_valid), 0);
      end
      if (k == 9) begin
        chk("wrap_redir_no_req", 32'(imem_req), 0);
        chk("wrap_redir_no_valid", 32'(instr_valid), 0);
      end
      if (k >= 10 && k <= 13) begin
        chk("wrap_req", 32'(imem_req), 1);
        chk("wrap_addr", 32'(imem_addr), 32'(wrap_addr[k-10]));
      end
    end

    // Full queue: one pop at count=3 with a push landing; count holds, order preserved.
    do_reset(1'b0);
    push_exp(8'h00, 32'h100); push_exp(8'h01, 32'h101);
    push_exp(8'h02, 32'h102); push_exp(8'h03, 32'h103);
    push_exp(8'h04, 32'h104); push_exp(8'h05, 32'h105);
    for (int k = 0; k < 13; k++) begin
      if (k > 0) tick();
      instr_ready = (k == 4) || (k >= 8);
      @(negedge clk);
      if (k < 4) chk("full_addr", 32'(imem_addr), 32'(k));
      if (k == 4) begin
        chk("full_pp_count", 32'(count), 3);
        chk("full_pp_req", 32'(imem_req), 0);
      end
      if (k == 5) begin
        chk("full_pp_count_hold", 32'(count), 3);
        chk("full_req_addr4", 32'(imem_addr), 4);
        chk("full_req4", 32'(imem_req), 1);
      end
      if (k == 6) chk("full_credit_req", 32'(imem_req), 0);
      if (k == 7) begin
        chk("full_count4", 32'(count), 4);
        chk("full_no_req", 32'(imem_req), 0);
      end
    end

    // Asynchronous reset between clock edges at count=3.
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      if (k == 4) chk("arst_pre_count", 32'(count), 3);
    end
    #1 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_req", 32'(imem_req), 0);
    rst = 1'b0;
    #1;
    chk("arst_restart_req", 32'(imem_req), 1);
    chk("arst_restart_addr", 32'(imem_addr), 0);
    tick();
    @(negedge clk);
    chk("arst_next_addr", 32'(imem_addr), 1);
    chk("arst_next_count", 32'(count), 0);

    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
